// File: rtl/instr_init_loader_pkg.sv
// Shared types and defaults for the instruction RAM init loader.
// The optional checksum feature is selected by INSTR_INIT_CHECKSUM_EN.
package instr_init_loader_pkg;

  localparam int WORD_W             = 9;
  localparam int DEF_INITWIDTH      = 12;
  localparam int DEF_INITLEN        = 2048;
  localparam int DEF_TOWIDTH        = 16;
  localparam int DEF_TIMEOUT_CYCLES = 65535;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/instr_init_loader_if.sv
// Boot-source handshake plus RAM init write port of the loader.
// master = boot source / RAM side, slave = the loader itself.
interface instr_init_loader_if
  import instr_init_loader_pkg::*;
#(
  parameter int INITWIDTH = DEF_INITWIDTH
) ();

  logic                 START;
  logic                 SRC_VALID;
  word_t                SRC_DATA;
  logic                 SRC_READY;
  logic [INITWIDTH-1:0] INITADDR;
  word_t                INITDATA;
  logic                 INITDATVAL;
  logic                 INITDONE;
  logic                 BUSY;
  logic                 ERROR;

  modport master (
    output START, SRC_VALID, SRC_DATA,
    input  SRC_READY, INITADDR, INITDATA, INITDATVAL, INITDONE, BUSY, ERROR
  );

  modport slave (
    input  START, SRC_VALID, SRC_DATA,
    output SRC_READY, INITADDR, INITDATA, INITDATVAL, INITDONE, BUSY, ERROR
  );

endinterface

// File: rtl/instr_init_stall_timer.sv
// Counts consecutive stalled LOAD cycles; flags expiry on the stalled cycle
// in which the count has already reached TIMEOUT_CYCLES-1.
module instr_init_stall_timer #(
  parameter int TOWIDTH        = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic CLK,
  input  logic RESET,
  input  logic i_clear,
  input  logic i_stall,
  output logic o_expire
);

  localparam logic [TOWIDTH-1:0] LIMIT = TOWIDTH'(TIMEOUT_CYCLES - 1);

  logic [TOWIDTH-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge CLK) begin
    if (RESET || i_clear) begin
      r_count <= '0;
    end else if (i_stall && (r_count != LIMIT)) begin
      r_count <= r_count + TOWIDTH'(1);
    end
  end

  assign o_expire = i_stall && (r_count == LIMIT);

endmodule

// File: rtl/instr_init_loader.sv
// Loads INITLEN 9-bit words from a valid/ready source into the instruction RAM
// init port. Define INSTR_INIT_CHECKSUM_EN to require a trailing checksum word.
module instr_init_loader
  import instr_init_loader_pkg::*;
#(
  parameter int INITWIDTH      = DEF_INITWIDTH,
  parameter int INITLEN        = DEF_INITLEN,
  parameter int TOWIDTH        = DEF_TOWIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic CLK,
  input  logic RESET,
  instr_init_loader_if.slave bus
);

  localparam logic [INITWIDTH-1:0] LAST_ADDR = INITWIDTH'(INITLEN - 1);

  state_t               r_state;
  logic [INITWIDTH-1:0] r_count;
  logic [INITWIDTH-1:0] r_addr;
  word_t                r_data;
  logic                 r_datval;
  logic                 r_done;
  logic                 r_busy;
  logic                 r_error;

  logic w_ready;
  logic w_hs;
  logic w_last;
  logic w_stall;
  logic w_start_ok;
  logic w_clear;
  logic w_expire;
  logic w_ck_word;
  logic w_sum_ok;

  assign w_ready    = (r_state == ST_LOAD);
  assign w_hs       = w_ready && bus.SRC_VALID;
  assign w_last     = (r_count == LAST_ADDR);
  assign w_stall    = w_ready && !bus.SRC_VALID;
  assign w_start_ok = bus.START &&
                      ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
  assign w_clear    = w_start_ok || w_hs;

  instr_init_stall_timer #(
    .TOWIDTH       (TOWIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_stall_timer (
    .CLK     (CLK),
    .RESET   (RESET),
    .i_clear (w_clear),
    .i_stall (w_stall),
    .o_expire(w_expire)
  );

`ifdef INSTR_INIT_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;

  word_t r_sum;
  logic  r_ck_phase;
  logic  r_sum_ok;

  // The word accepted after the last data word is the checksum, never written.
  always_ff @(posedge CLK) begin
    if (RESET || w_start_ok) begin
      r_sum      <= '0;
      r_ck_phase <= 1'b0;
      r_sum_ok   <= 1'b0;
    end else if (w_hs) begin
      if (r_ck_phase) begin
        r_sum_ok <= (r_sum == bus.SRC_DATA);
      end else begin
        r_sum <= r_sum + bus.SRC_DATA;
        if (w_last) r_ck_phase <= 1'b1;
      end
    end
  end

  assign w_ck_word = r_ck_phase;
  assign w_sum_ok  = r_sum_ok;
`else
  localparam bit CK_EN = 1'b0;

  assign w_ck_word = 1'b0;
  assign w_sum_ok  = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_datval <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_datval <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (bus.START) begin
            r_state <= ST_LOAD;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_error <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (w_expire) begin
            r_state <= ST_ERR;
            r_busy  <= 1'b0;
            r_error <= 1'b1;
          end else if (w_hs) begin
            if (w_ck_word) begin
              r_state <= ST_DRAIN;
            end else begin
              r_addr   <= r_count;
              r_data   <= bus.SRC_DATA;
              r_datval <= 1'b1;
              // Count parks on the last address so INITADDR never wraps.
              if (!w_last)     r_count <= r_count + INITWIDTH'(1);
              else if (!CK_EN) r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          r_busy <= 1'b0;
          if (w_sum_ok) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_ERR;
            r_error <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.SRC_READY  = w_ready;
  assign bus.INITADDR   = r_addr;
  assign bus.INITDATA   = r_data;
  assign bus.INITDATVAL = r_datval;
  assign bus.INITDONE   = r_done;
  assign bus.BUSY       = r_busy;
  assign bus.ERROR      = r_error;

endmodule
